// File: rtl/traffic_pkg.sv
// Shared phase encoding and default timing values for the traffic light scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } tl_state_e;

    localparam logic [1:0] PH_ALL_RED = 2'b00;
    localparam logic [1:0] PH_GREEN   = 2'b01;
    localparam logic [1:0] PH_YELLOW  = 2'b10;

    localparam int DEF_N_LANES      = 4;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_GREEN_MIN    = 3;
    localparam int DEF_GREEN_MAX    = 6;
    localparam int DEF_YELLOW_TIME  = 2;
    localparam int DEF_ALL_RED_TIME = 1;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin lane search: first requesting lane after last_i, wrapping, with last_i itself checked last.
module tlc_rr_pick #(
    parameter int N_LANES = 4
) (
    input  logic [N_LANES-1:0]         req_i,
    input  logic [$clog2(N_LANES)-1:0] last_i,
    output logic                       valid_o,
    output logic [$clog2(N_LANES)-1:0] index_o
);
    localparam int LW = $clog2(N_LANES);

    int k;

    always_comb begin
        valid_o = 1'b0;
        index_o = last_i;
        k       = 0;
        for (int off = 1; off <= N_LANES; off++) begin
            k = (int'(last_i) + off) % N_LANES;
            if (!valid_o && req_i[k]) begin
                valid_o = 1'b1;
                index_o = LW'(k);
            end
        end
    end

endmodule

// File: rtl/traffic_light_sched.sv
// Multi-lane traffic light phase scheduler (ALL_RED -> GREEN -> YELLOW), tick-driven Moore FSM.
// Optional EMERGENCY_PREEMPT_EN adds emg_req/emg_lane preemption.
//
//   state      | meaning
//   ST_ALL_RED | all lanes red; on expiry pick next demanding lane round-robin
//   ST_GREEN   | lane_idx green; held by min/max/rest-in-green rules
//   ST_YELLOW  | lane_idx yellow for YELLOW_TIME ticks, then ALL_RED
module traffic_light_sched
    import traffic_pkg::*;
#(
    parameter int N_LANES      = DEF_N_LANES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int GREEN_MIN    = DEF_GREEN_MIN,
    parameter int GREEN_MAX    = DEF_GREEN_MAX,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [N_LANES-1:0]         S1,
    input  logic [N_LANES-1:0]         S5,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                       emg_req,
    input  logic [$clog2(N_LANES)-1:0] emg_lane,
`endif
    output logic [N_LANES-1:0]         green,
    output logic [N_LANES-1:0]         yellow,
    output logic [1:0]                 phase,
    output logic [$clog2(N_LANES)-1:0] lane_idx
);
    localparam int LW = $clog2(N_LANES);

    localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] TIMER_SAT  = '1;
    localparam logic [N_LANES-1:0] LANE_ONE = N_LANES'(1);

    tl_state_e          state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [N_LANES-1:0] green_q, yellow_q;

    logic               pick_valid;
    logic [LW-1:0]      pick_idx;
    logic               own_req, other_req, green_hold, phase_chg;
    logic [N_LANES-1:0] lane_mask, lane_d_mask;

    tlc_rr_pick #(.N_LANES(N_LANES)) u_rr_pick (
        .req_i   (S1),
        .last_i  (lane_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    always_comb begin
        lane_mask   = LANE_ONE << lane_q;
        own_req     = S1[lane_q];
        other_req   = |(S1 & ~lane_mask);
        green_hold  = (timer_q < GMIN_LAST)
                    | (own_req & S5[lane_q] & (timer_q < GMAX_LAST))
                    | (own_req & ~other_req);
`ifdef EMERGENCY_PREEMPT_EN
        // An active emergency overrides every green timing rule.
        if (emg_req) begin
            green_hold = (emg_lane == lane_q);
        end
`endif
        state_d   = state_q;
        lane_d    = lane_q;
        timer_d   = timer_q;
        phase_chg = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_ALL_RED: begin
                    if (timer_q >= AR_LAST) begin
`ifdef EMERGENCY_PREEMPT_EN
                        if (emg_req) begin
                            state_d   = ST_GREEN;
                            lane_d    = emg_lane;
                            phase_chg = 1'b1;
                        end else
`endif
                        if (pick_valid) begin
                            state_d   = ST_GREEN;
                            lane_d    = pick_idx;
                            phase_chg = 1'b1;
                        end
                    end
                end
                ST_GREEN: begin
                    if (!green_hold) begin
                        state_d   = ST_YELLOW;
                        phase_chg = 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (timer_q >= Y_LAST) begin
                        state_d   = ST_ALL_RED;
                        phase_chg = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_ALL_RED;
                    phase_chg = 1'b1;
                end
            endcase

            if (phase_chg) begin
                timer_d = '0;
            end else if (timer_q != TIMER_SAT) begin
                timer_d = timer_q + 1'b1;
            end
        end

        lane_d_mask = LANE_ONE << lane_d;
    end

    // Lamp outputs are registered from the next state so they change in the same cycle as state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ALL_RED;
            lane_q   <= LW'(N_LANES - 1);
            timer_q  <= '0;
            green_q  <= '0;
            yellow_q <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            timer_q  <= timer_d;
            green_q  <= (state_d == ST_GREEN)  ? lane_d_mask : '0;
            yellow_q <= (state_d == ST_YELLOW) ? lane_d_mask : '0;
        end
    end

    assign green    = green_q;
    assign yellow   = yellow_q;
    assign phase    = state_q;
    assign lane_idx = lane_q;

endmodule

// File: tb/tb_traffic_light_sched.sv
// Scoreboard bench for traffic_light_sched; a reference model pushes expected outputs per driven cycle.
// Build with EMERGENCY_PREEMPT_EN to also exercise preemption.
module tb_traffic_light_sched;
    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int TSAT = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst, tick;
    logic [N-1:0] S1, S5;
    logic [N-1:0] green, yellow;
    logic [1:0]   phase;
    logic [1:0]   lane_idx;
`ifdef EMERGENCY_PREEMPT_EN
    logic         emg_req;
    logic [1:0]   emg_lane;
`endif

    always #5 clk = ~clk;

    traffic_light_sched #(
        .N_LANES(N), .CNT_W(CW), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .S1       (S1),
        .S5       (S5),
`ifdef EMERGENCY_PREEMPT_EN
        .emg_req  (emg_req),
        .emg_lane (emg_lane),
`endif
        .green    (green),
        .yellow   (yellow),
        .phase    (phase),
        .lane_idx (lane_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    int m_ph   = 0;
    int m_lane = N - 1;
    int m_t    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_bump();
        if (m_t < TSAT) m_t++;
    endtask

    task automatic model_step(input logic t, input logic [N-1:0] s1, input logic [N-1:0] s5,
                              input logic r, input logic er, input logic [1:0] el);
        bit   found, hold, own, oth;
        int   nl, idx;
        found = 0; hold = 0; nl = 0; idx = 0;
        if (r) begin
            m_ph = 0; m_lane = N - 1; m_t = 0;
        end else if (t) begin
            case (m_ph)
                0: begin
                    if (m_t >= ART - 1) begin
                        if (er) begin
                            found = 1; nl = int'(el);
                        end else begin
                            for (int off = 1; off <= N; off++) begin
                                idx = (m_lane + off) % N;
                                if (!found && s1[idx]) begin
                                    found = 1; nl = idx;
                                end
                            end
                        end
                    end
                    if (found) begin
                        m_ph = 1; m_lane = nl; m_t = 0;
                    end else m_bump();
                end
                1: begin
                    own = s1[m_lane];
                    oth = 0;
                    for (int j = 0; j < N; j++) if (j != m_lane && s1[j]) oth = 1;
                    if (er) hold = (int'(el) == m_lane);
                    else hold = (m_t < GMIN - 1) || (own && s5[m_lane] && m_t < GMAX - 1) || (own && !oth);
                    if (hold) m_bump();
                    else begin
                        m_ph = 2; m_t = 0;
                    end
                end
                default: begin
                    if (m_t >= YT - 1) begin
                        m_ph = 0; m_t = 0;
                    end else m_bump();
                end
            endcase
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [N-1:0] oh;
        oh = 4'b0001 << m_lane;
        return {2'(m_ph), 2'(m_lane), (m_ph == 1) ? oh : 4'b0, (m_ph == 2) ? oh : 4'b0};
    endfunction

    task automatic cyc(input logic t, input logic [N-1:0] s1, input logic [N-1:0] s5,
                       input logic r, input logic er, input logic [1:0] el);
        logic [11:0] e;
        @(negedge clk);
        rst = r; tick = t; S1 = s1; S5 = s5;
`ifdef EMERGENCY_PREEMPT_EN
        emg_req = er; emg_lane = el;
`endif
        model_step(t, s1, s5, r, er, el);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("sb_outputs", {20'b0, phase, lane_idx, green, yellow}, {20'b0, e});
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'b0101, 4'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b0, 4'b0101, 4'b0, 1'b1, 1'b0, 2'd0);
    endtask

    int cnt_g, cnt_y;

    initial begin
        rst = 1'b1; tick = 1'b0; S1 = '0; S5 = '0;
`ifdef EMERGENCY_PREEMPT_EN
        emg_req = 1'b0; emg_lane = 2'd0;
`endif
        // Reset state and the alternating two-lane pattern.
        do_reset();
        check_val("rst_phase", 32'(phase), 32'd0);
        check_val("rst_lane", 32'(lane_idx), 32'd3);
        check_val("rst_green", 32'(green), 32'd0);
        check_val("rst_yellow", 32'(yellow), 32'd0);
        cyc(1'b1, 4'b0101, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("alt_first_green", 32'(green), 32'b0001);
        cnt_g = 0; cnt_y = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 4'b0101, 4'b0, 1'b0, 1'b0, 2'd0);
            if (green != 0) cnt_g++;
            if (yellow != 0) cnt_y++;
        end
        check_val("alt_green_cycles", 32'(cnt_g), 32'd12);
        check_val("alt_yellow_cycles", 32'(cnt_y), 32'd8);

        // Congestion extends lane0 to GREEN_MAX.
        do_reset();
        cnt_g = 0; cnt_y = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd0);
            if (green[0]) cnt_g++;
            if (green[1]) cnt_y++;
        end
        check_val("cong_lane0_len", 32'(cnt_g), 32'd6);
        check_val("cong_lane1_len", 32'(cnt_y), 32'd3);

        // Rest in green, then new demand forces yellow.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'b0001, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("rest_green", 32'(green), 32'b0001);
        cyc(1'b1, 4'b1001, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("rest_to_yellow", 32'(phase), 32'd2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1001, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("rest_next_lane3", 32'(green), 32'b1000);

        // Idle, tick freeze, reset mid-yellow.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'b0000, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("idle_phase", 32'(phase), 32'd0);
        check_val("idle_lamps", 32'({green, yellow}), 32'd0);
        cyc(1'b1, 4'b0100, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("idle_wake_lane2", 32'(green), 32'b0100);
        cyc(1'b1, 4'b0110, 4'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0, 2'd0);
        check_val("freeze_green", 32'(green), 32'b0100);
        cyc(1'b1, 4'b0110, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("freeze_min_hold", 32'(green), 32'b0100);
        cyc(1'b1, 4'b0110, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("freeze_then_yellow", 32'(phase), 32'd2);
        cyc(1'b0, 4'b0110, 4'b0, 1'b1, 1'b0, 2'd0);
        check_val("rst_mid_yellow_phase", 32'(phase), 32'd0);
        check_val("rst_mid_yellow_lane", 32'(lane_idx), 32'd3);
        check_val("rst_mid_yellow_lamp", 32'(yellow), 32'd0);

        // Timer saturation during a long rest in green.
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1'b1, 4'b0001, 4'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 4'b0011, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("sat_to_yellow", 32'(phase), 32'd2);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'b0, 1'b0, 2'd0);
        end

`ifdef EMERGENCY_PREEMPT_EN
        do_reset();
        cyc(1'b1, 4'b0001, 4'b0, 1'b0, 1'b0, 2'd0);
        check_val("emg_start_lane0", 32'(green), 32'b0001);
        cyc(1'b1, 4'b0001, 4'b0, 1'b0, 1'b1, 2'd2);
        check_val("emg_preempt_yellow", 32'(phase), 32'd2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 4'b0, 1'b0, 1'b1, 2'd2);
        check_val("emg_green_lane2", 32'(green), 32'b0100);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'b0011, 4'b0, 1'b0, 1'b1, 2'd2);
        check_val("emg_hold_lane2", 32'(green), 32'b0100);
        cyc(1'b1, 4'b0011, 4'b0, 1'b0, 1'b0, 2'd2);
        check_val("emg_release", 32'(phase), 32'd2);
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'b0,
                ($urandom_range(0, 5) == 0), 2'($urandom));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_sched.md
TRAFFIC_LIGHT_SCHED -- requirements
Module: traffic_light_sched

Interface
REQ-001 SHALL have parameter N_LANES, default 4, number of lanes (>=2).
REQ-002 SHALL have parameter CNT_W, default 8, phase timer width.
REQ-003 SHALL have parameters GREEN_MIN=3, GREEN_MAX=6, YELLOW_TIME=2, ALL_RED_TIME=1, in ticks; 1<=GREEN_MIN<=GREEN_MAX<2^CNT_W; YELLOW_TIME, ALL_RED_TIME >=1.
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: tick in 1 timebase enable; S1 in N_LANES car-present per lane; S5 in N_LANES congestion per lane.
REQ-006 SHALL have outputs: green out N_LANES one-hot; yellow out N_LANES one-hot; phase out 2 (ALL_RED=00, GREEN=01, YELLOW=10); lane_idx out clog2(N_LANES) lane being served.

Function
REQ-007 SHALL implement FSM states ALL_RED, GREEN, YELLOW; all outputs driven registered from state/lane registers only (Moore).
REQ-008 SHALL keep timer = ticks elapsed in current phase; increments only on tick, saturates at 2^CNT_W-1, clears on every phase change.
REQ-009 SHALL evaluate transitions only on cycles with tick=1, using S1/S5 sampled that cycle; tick=0 freezes state, lane and timer.
REQ-010 ALL_RED: on tick with timer>=ALL_RED_TIME-1, SHALL pick first lane k with S1[k]=1, searching lane_idx+1 ... lane_idx+N_LANES mod N_LANES (wraps N_LANES-1 -> 0, current lane last), then enter GREEN on k.
REQ-011 ALL_RED with S1==0 SHALL remain ALL_RED, green=yellow=0, re-searching on every tick.
REQ-012 GREEN before timer reaches GREEN_MIN-1 SHALL stay GREEN regardless of S1/S5.
REQ-013 GREEN with timer>=GREEN_MIN-1 SHALL hold if (S5[lane] & S1[lane] & timer<GREEN_MAX-1) or (S1[lane] & no other S1 bit set); else enter YELLOW.
REQ-014 Rest-in-green per REQ-013 SHALL be unbounded while no other lane demands; new demand on another lane after GREEN_MAX SHALL force YELLOW on the next tick.
REQ-015 YELLOW SHALL last exactly YELLOW_TIME ticks then enter ALL_RED, same lane_idx.
REQ-016 green[lane_idx]=1 only in GREEN, yellow[lane_idx]=1 only in YELLOW; never more than one bit set across green|yellow.

Reset
REQ-017 rst SHALL, at the next clk edge regardless of tick or current phase, set phase=ALL_RED, timer=0, lane_idx=N_LANES-1 (first search starts at lane 0), green=0, yellow=0.
REQ-018 rst asserted mid-GREEN or mid-YELLOW SHALL abort the phase with no yellow completion.

Configuration
REQ-019 Macro EMERGENCY_PREEMPT_EN defined SHALL add inputs emg_req (1) and emg_lane (clog2(N_LANES)).
REQ-020 With EMERGENCY_PREEMPT_EN: emg_req on tick during GREEN on lane!=emg_lane SHALL enter YELLOW ignoring GREEN_MIN; ALL_RED expiry SHALL select emg_lane ignoring S1; GREEN on emg_lane SHALL hold while emg_req=1 ignoring GREEN_MAX.
REQ-021 Without EMERGENCY_PREEMPT_EN: ports absent, behaviour exactly REQ-007..REQ-016.

Structure
REQ-022 Shared package traffic_pkg SHALL hold phase encoding constants and default timing parameter values.
REQ-023 Round-robin next-lane search SHALL be a combinational sub-module tlc_rr_pick (inputs req vector, last lane; outputs valid, index).

Verification (N_LANES=4, defaults, tick=1 every cycle unless stated)
REQ-024 rst, S1=0101, S5=0 -> ALL_RED 1, green lane0 3, yellow 2, ALL_RED 1, green lane2 3, ... alternating 0/2 forever.
REQ-025 S1=0011, S5=0001 -> lane0 green 6 ticks (GREEN_MAX), yellow 2, ALL_RED 1, lane1 green 3.
REQ-026 S1=0001 -> lane0 green indefinitely; set S1[3]=1 at cycle 20 -> yellow next tick, then ALL_RED, then green lane3.
REQ-027 S1=0 for 10 cycles -> phase=00, green=yellow=0; raise S1[2] -> green[2] registered after next ALL_RED tick; tick held 0 for 5 cycles mid-green -> outputs and timer frozen; rst mid-yellow -> next cycle ALL_RED, lane_idx=3.
REQ-028 EMERGENCY_PREEMPT_EN, lane0 green at timer=0, emg_req=1, emg_lane=2 -> yellow next tick, ALL_RED, green lane2 held while emg_req=1 past 6 ticks, released to normal rules when emg_req=0.
